// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue controller in front of a two-cycle-latency ALU. Commands are queued
//   in a DEPTH-entry command FIFO and issued to the ALU only when a result
//   slot is guaranteed. Returning results are collected in a DEPTH-entry
//   result FIFO and leave in acceptance order.
//
//   Credits = DEPTH - result-FIFO count - in-flight count. Reserving a slot at
//   issue time means a returning result can never find the result FIFO full.
//
// Configuration macro:
//   ALU_ISSUE_BYPASS_EN - when defined, a command arriving while the command
//                         FIFO is empty (and a credit exists) goes straight
//                         to the ALU in the same cycle without being queued.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           upstream command handshake
//   in_a, in_b, in_op           command operands and opcode
//   alu_a, alu_b, alu_op        ALU inputs (all zero as a bubble)
//   alu_res, alu_carry          ALU outputs, valid two cycles after issue
//   res_valid/res_ready         downstream result handshake
//   res_data, res_carry         head result
//   busy                        any command queued, in flight, or result held
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [2:0] in_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_res,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t          cmd_mem [DEPTH];
  logic [8:0]    res_mem [DEPTH];

  logic [AW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [AW-1:0] res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [CW-1:0] cmd_cnt_q, cmd_cnt_d, res_cnt_q, res_cnt_d;
  logic [1:0]    inflight_q, inflight_d;  // [0]: issued last cycle, [1]: result now on alu_res

  logic          cmd_empty, cmd_full, res_empty;
  logic [CW-1:0] in_flight_cnt, credits;
  logic          has_credit, bypass, issue;
  logic          cmd_push, cmd_pop, res_push, res_pop;
  cmd_t          issue_cmd;

  assign cmd_empty     = (cmd_cnt_q == '0);
  assign cmd_full      = (cmd_cnt_q == CW'(DEPTH));
  assign res_empty     = (res_cnt_q == '0);
  assign in_flight_cnt = CW'(inflight_q[0]) + CW'(inflight_q[1]);
  assign credits       = CW'(DEPTH) - res_cnt_q - in_flight_cnt;
  assign has_credit    = (credits != '0);

`ifdef ALU_ISSUE_BYPASS_EN
  // rst_n gates the bypass so the ALU sees bubbles while reset is held even
  // if upstream keeps in_valid asserted.
  assign bypass = rst_n & cmd_empty & in_valid & has_credit;
`else
  assign bypass = 1'b0;
`endif

  // Readiness reflects FIFO occupancy only, never this cycle's issue decision.
  assign in_ready  = ~cmd_full;
  assign issue     = has_credit & (~cmd_empty | bypass);
  assign issue_cmd = cmd_empty ? cmd_t'{a: in_a, b: in_b, op: in_op} : cmd_mem[cmd_rd_q];

  assign alu_a  = issue ? issue_cmd.a  : 8'h00;
  assign alu_b  = issue ? issue_cmd.b  : 8'h00;
  assign alu_op = issue ? issue_cmd.op : 3'b000;

  assign cmd_push = in_valid & in_ready & ~bypass;
  assign cmd_pop  = issue & ~cmd_empty;
  // Only tracked issues are captured, so bubbles never enter the result FIFO.
  // Credits guarantee a free slot whenever this push happens.
  assign res_push = inflight_q[1];
  assign res_pop  = res_valid & res_ready;

  assign res_valid = ~res_empty;
  // Gated by res_valid so stale storage is never visible, including in reset.
  assign res_data  = res_valid ? res_mem[res_rd_q][7:0] : 8'h00;
  assign res_carry = res_valid ? res_mem[res_rd_q][8]   : 1'b0;
  assign busy      = ~cmd_empty | (inflight_q != 2'b00) | ~res_empty;

  // NOTE: every next-state value is assigned unconditionally here, so no
  // path through the block leaves a variable unassigned and no latch forms.
  always_comb begin
    cmd_wr_d   = cmd_push ? cmd_wr_q + 1'b1 : cmd_wr_q;
    cmd_rd_d   = cmd_pop  ? cmd_rd_q + 1'b1 : cmd_rd_q;
    res_wr_d   = res_push ? res_wr_q + 1'b1 : res_wr_q;
    res_rd_d   = res_pop  ? res_rd_q + 1'b1 : res_rd_q;
    cmd_cnt_d  = cmd_cnt_q + CW'(cmd_push) - CW'(cmd_pop);
    res_cnt_d  = res_cnt_q + CW'(res_push) - CW'(res_pop);
    inflight_d = {inflight_q[0], issue};
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      res_cnt_q  <= '0;
      inflight_q <= 2'b00;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      res_cnt_q  <= res_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; clearing pointers and
  // counts empties the queues, and outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_q] <= cmd_t'{a: in_a, b: in_b, op: in_op};
    if (res_push) res_mem[res_wr_q] <= {alu_carry, alu_res};
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Scoreboard bench for alu_issue_ctrl (DEPTH = 4). A behavioural two-cycle
//   ALU sits on the alu_* side. The driver pushes the expected {carry, data}
//   of each accepted command into a queue; an independent monitor pops and
//   compares on every result handshake.
//   ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT,
//   110 SLL, 111 SRL; carry is the ADD carry-out / SUB borrow, else 0.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [2:0] in_op = 3'b000;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_carry;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int issues   = 0;

  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] exp;  // {carry, data}
  } vec_t;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res),
    .alu_carry(alu_carry),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_carry(res_carry),
    .busy     (busy)
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {1'b0, a << 1};
      default: return {1'b0, a >> 1};
    endcase
  endfunction

  // Behavioural ALU: result of the cycle-T inputs is visible during T+2.
  logic [8:0] st1, st2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1 <= '0;
      st2 <= '0;
    end else begin
      st1 <= alu_f(alu_a, alu_b, alu_op);
      st2 <= st1;
    end
  end
  assign {alu_carry, alu_res} = st2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every stimulus vector has a non-zero a operand, so non-zero alu_a marks an issue.
  always @(negedge clk) if (rst_n && alu_a != 8'h00) issues++;

  // Monitor: compare each handshaken result with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("unexpected_res", {23'd0, res_carry, res_data}, 32'h1ff);
      else check("res", {23'd0, res_carry, res_data}, {23'd0, exp_q.pop_front()});
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input vec_t v);
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else exp_q.push_back(v.exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_bits"}, {res_carry, res_data}, 0);
    check({tag, "_alu_bits"}, {alu_op, alu_a, alu_b}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    cycles(2);
  endtask

  vec_t bp_v[8] = '{
    '{8'h01, 8'h02, 3'd0, 9'h003}, '{8'hFF, 8'h01, 3'd0, 9'h100},
    '{8'h10, 8'h01, 3'd1, 9'h00F}, '{8'hF0, 8'h3C, 3'd2, 9'h030},
    '{8'hF0, 8'h0F, 3'd3, 9'h0FF}, '{8'hAA, 8'hFF, 3'd4, 9'h055},
    '{8'h81, 8'h00, 3'd6, 9'h002}, '{8'h80, 8'h80, 3'd0, 9'h100}
  };
  vec_t mix_v[3] = '{
    '{8'h05, 8'h07, 3'd1, 9'h1FE}, '{8'h0F, 8'h00, 3'd5, 9'h0F0},
    '{8'h81, 8'h00, 3'd7, 9'h040}
  };

  initial begin
    vec_t v;
    int   lat;
    int   base;
    int   bad;

    // Reset state
    check_reset_outputs("rst");
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Single ADD with latency measured from the accepting edge
    send('{8'hF0, 8'h20, 3'd0, 9'h110});
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid) break;
      lat++;
    end
`ifdef ALU_ISSUE_BYPASS_EN
    check("add_latency", lat, 2);
`else
    check("add_latency", lat, 3);
`endif
    drain("add");

    // Back-pressure: only DEPTH issues while results are held
    res_ready = 1'b0;
    base = issues;
    foreach (bp_v[i]) send(bp_v[i]);
    cycles(10);
    @(negedge clk);
    check("bp_issue_count", issues - base, DEPTH);
    check("bp_in_ready", in_ready, 0);
    check("bp_res_valid", res_valid, 1);
    check("bp_busy", busy, 1);
    cycles(1);
    res_ready = 1'b1;
    drain("bp");

    // Mixed stream
    foreach (mix_v[i]) send(mix_v[i]);
    drain("mix");

    // Reset mid-stream with results held, in flight and queued
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v = '{8'(8'h11 * (i + 1)), 8'h01, 3'd0, 9'h000};
      send(v);
      if (i == 1) cycles(6);
    end
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    check_reset_outputs("mid_rst");
    cycles(2);
    rst_n = 1'b1;
    res_ready = 1'b1;
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid || busy) bad++;
    end
    check("mid_post_reset_quiet", bad, 0);
    cycles(1);

    // Wrap-around with random downstream back-pressure
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v.a = 8'(i * 7 + 1);
          v.b = 8'(i * 3 + 5);
          v.op = 3'(i);
          v.exp = alu_f(v.a, v.b, v.op);
          send(v);
        end
      end
      begin
        repeat (150) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    drain("wrap");
    @(negedge clk);
    check("final_busy", busy, 0);
    check("final_res_valid", res_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
